// File: rtl/pagerank_partition_scheduler.sv
// PageRank partition scheduler: per iteration, scatters every partition in turn and then runs
// one gather phase. A watchdog bounds each scatter or gather phase.
module pagerank_partition_scheduler #(
    parameter int NUM_PARTITIONS = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int PSEL_W = (NUM_PARTITIONS > 1) ? $clog2(NUM_PARTITIONS) : 1,
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        num_iterations,
    input  logic              scatter_done,
    input  logic              gather_done,
    output logic              scatter_restart,
    output logic              scatter_enable,
    output logic [PSEL_W-1:0] partition_sel,
    output logic              gather_start,
    output logic [7:0]        iteration_count,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCATTER,
        S_NEXT_PART,
        S_GATHER,
        S_NEXT_ITER,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [PSEL_W-1:0] PSEL_LAST = PSEL_W'(NUM_PARTITIONS - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PSEL_W-1:0] r_psel;
    logic [PSEL_W-1:0] w_psel_nxt;
    logic [7:0]        r_iter;
    logic [7:0]        w_iter_nxt;
    logic [7:0]        r_iter_target;
    logic [7:0]        w_iter_target_nxt;
    logic [WDOG_W-1:0] r_wdog;
    logic [WDOG_W-1:0] w_wdog_nxt;
    logic              w_wdog_expired;
    logic [7:0]        w_iter_inc;

    assign w_wdog_expired = (r_wdog == WDOG_LAST);
    assign w_iter_inc     = r_iter + 8'd1;

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register updates from its pre-edge value.
        if (reset) begin
            r_state       <= S_IDLE;
            r_psel        <= '0;
            r_iter        <= '0;
            r_iter_target <= '0;
            r_wdog        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_psel        <= w_psel_nxt;
            r_iter        <= w_iter_nxt;
            r_iter_target <= w_iter_target_nxt;
            r_wdog        <= w_wdog_nxt;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        w_state_nxt       = r_state;
        w_psel_nxt        = r_psel;
        w_iter_nxt        = r_iter;
        w_iter_target_nxt = r_iter_target;
        w_wdog_nxt        = r_wdog;

        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        w_iter_target_nxt = num_iterations;
                        w_iter_nxt        = '0;
                        w_psel_nxt        = '0;
                        w_state_nxt       = (num_iterations == 8'd0) ? S_DONE : S_LOAD;
                    end else if (r_state == S_DONE) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_LOAD: begin
                    w_wdog_nxt  = '0;
                    w_state_nxt = S_SCATTER;
                end
                // A done input in the expiry cycle still counts as success.
                S_SCATTER: begin
                    if (scatter_done) begin
                        w_state_nxt = S_NEXT_PART;
                    end else if (w_wdog_expired) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_wdog_nxt = r_wdog + WDOG_W'(1);
                    end
                end
                S_NEXT_PART: begin
                    if (r_psel == PSEL_LAST) begin
                        w_wdog_nxt  = '0;
                        w_state_nxt = S_GATHER;
                    end else begin
                        w_psel_nxt  = r_psel + PSEL_W'(1);
                        w_state_nxt = S_LOAD;
                    end
                end
                S_GATHER: begin
                    if (gather_done) begin
                        w_state_nxt = S_NEXT_ITER;
                    end else if (w_wdog_expired) begin
                        w_state_nxt = S_ERROR;
                    end else begin
                        w_wdog_nxt = r_wdog + WDOG_W'(1);
                    end
                end
                S_NEXT_ITER: begin
                    w_iter_nxt  = w_iter_inc;
                    w_psel_nxt  = '0;
                    w_state_nxt = (w_iter_inc == r_iter_target) ? S_DONE : S_LOAD;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // The watchdog is cleared on GATHER entry, so a zero count marks the first GATHER cycle.
    assign scatter_restart = (r_state == S_LOAD);
    assign scatter_enable  = (r_state == S_SCATTER);
    assign gather_start    = (r_state == S_GATHER) && (r_wdog == '0);
    assign partition_sel   = r_psel;
    assign iteration_count = r_iter;
    assign busy            = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
    assign done            = (r_state == S_DONE);
    assign error           = (r_state == S_ERROR);

endmodule

// File: tb/tb_pagerank_partition_scheduler.sv
// Bench for pagerank_partition_scheduler: three instances (4, 2 and 1 partitions) checked every
// cycle against an expected-output timeline built from run parameters, plus literal spot checks.
module tb_pagerank_partition_scheduler;

    localparam int ND = 3;

    typedef struct packed {
        logic       restart;
        logic       enable;
        logic [7:0] psel;
        logic       gstart;
        logic [7:0] iter;
        logic       busy;
        logic       done;
        logic       error;
    } vec_t;

    int part_n [ND] = '{4, 2, 1};
    int tout_n [ND] = '{8, 16, 16};

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] num_iter = 8'd0;
    logic       start   [ND] = '{default: 1'b0};
    logic       abort   [ND] = '{default: 1'b0};
    logic       sdone   [ND] = '{default: 1'b0};
    logic       gdone   [ND] = '{default: 1'b0};
    logic       s_force [ND] = '{default: 1'b0};
    vec_t       dout    [ND];

    int s_lat  [ND] = '{default: 0};
    int g_lat  [ND] = '{default: 0};
    int s_cnt  [ND] = '{default: 0};
    int g_cnt  [ND] = '{default: 0};
    int rs_cnt [ND] = '{default: 0};
    int gs_cnt [ND] = '{default: 0};
    int dn_cnt [ND] = '{default: 0};

    vec_t exp_v [int];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int GP = (g == 0) ? 4 : (g == 1) ? 2 : 1;
        localparam int GT = (g == 0) ? 8 : 16;
        localparam int GW = (GP > 1) ? $clog2(GP) : 1;
        logic          rs, en, gs, bsy, dn, er;
        logic [GW-1:0] ps;
        logic [7:0]    it;
        pagerank_partition_scheduler #(.NUM_PARTITIONS(GP), .TIMEOUT_CYCLES(GT)) u_dut (
            .clock(clock), .reset(reset), .start(start[g]), .abort(abort[g]),
            .num_iterations(num_iter), .scatter_done(sdone[g]), .gather_done(gdone[g]),
            .scatter_restart(rs), .scatter_enable(en), .partition_sel(ps),
            .gather_start(gs), .iteration_count(it), .busy(bsy), .done(dn), .error(er)
        );
        assign dout[g] = '{restart: rs, enable: en, psel: 8'(ps), gstart: gs,
                           iter: it, busy: bsy, done: dn, error: er};
    end

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic int ek(int d, int c);
        return c * ND + d;
    endfunction

    function automatic vec_t mk(logic rs, logic en, int ps, logic gs, int it,
                                logic bsy, logic dn, logic er);
        return '{restart: rs, enable: en, psel: 8'(ps), gstart: gs,
                 iter: 8'(it), busy: bsy, done: dn, error: er};
    endfunction

    function automatic void put(int d, int c, vec_t v);
        exp_v[ek(d, c)] = v;
    endfunction

    // Expected outputs for a run whose start is sampled at the end of cycle c0; returns the last
    // cycle with an expectation. Phases: per partition LOAD(1), SCATTER(L), NEXT_PART(1); then
    // GATHER(G), NEXT_ITER(1); finally DONE(1). A phase longer than T cycles ends in ERROR.
    function automatic int build_run(int d, int c0, int n);
        int t  = c0 + 1;
        int pn = part_n[d];
        int tm = tout_n[d];
        int sl = s_lat[d];
        int gl = g_lat[d];
        if (n == 0) begin
            put(d, t, mk(0, 0, 0, 0, 0, 0, 1, 0));
            put(d, t + 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
            return t + 1;
        end
        for (int it = 0; it < n; it++) begin
            for (int p = 0; p < pn; p++) begin
                put(d, t++, mk(1, 0, p, 0, it, 1, 0, 0));
                for (int k = 0; k < ((sl != 0 && sl <= tm) ? sl : tm); k++)
                    put(d, t++, mk(0, 1, p, 0, it, 1, 0, 0));
                if (sl == 0 || sl > tm) begin
                    put(d, t++, mk(0, 0, p, 0, it, 0, 0, 1));
                    put(d, t, mk(0, 0, p, 0, it, 0, 0, 1));
                    return t;
                end
                put(d, t++, mk(0, 0, p, 0, it, 1, 0, 0));
            end
            for (int k = 0; k < ((gl != 0 && gl <= tm) ? gl : tm); k++)
                put(d, t++, mk(0, 0, pn - 1, (k == 0), it, 1, 0, 0));
            if (gl == 0 || gl > tm) begin
                put(d, t++, mk(0, 0, pn - 1, 0, it, 0, 0, 1));
                put(d, t, mk(0, 0, pn - 1, 0, it, 0, 0, 1));
                return t;
            end
            put(d, t++, mk(0, 0, pn - 1, 0, it, 1, 0, 0));
        end
        put(d, t++, mk(0, 0, 0, 0, n, 0, 1, 0));
        put(d, t, mk(0, 0, 0, 0, n, 0, 0, 0));
        return t;
    endfunction

    function automatic int g_next(int d);
        if (dout[d].gstart) return 1;
        if (g_cnt[d] != 0 && g_cnt[d] < 1000) return g_cnt[d] + 1;
        return g_cnt[d];
    endfunction

    // Engine responders: done arrives on the s_lat-th / g_lat-th cycle of a phase (0 = never).
    always @(negedge clock) begin
        for (int d = 0; d < ND; d++) begin
            s_cnt[d]  <= dout[d].enable ? s_cnt[d] + 1 : 0;
            sdone[d]  <= s_force[d] |
                         (dout[d].enable && s_lat[d] != 0 && (s_cnt[d] + 1 == s_lat[d]));
            g_cnt[d]  <= g_next(d);
            gdone[d]  <= (g_lat[d] != 0) && (g_next(d) == g_lat[d]);
            rs_cnt[d] <= rs_cnt[d] + int'(dout[d].restart);
            gs_cnt[d] <= gs_cnt[d] + int'(dout[d].gstart);
            dn_cnt[d] <= dn_cnt[d] + int'(dout[d].done);
        end
    end

    always @(negedge clock) begin
        for (int d = 0; d < ND; d++) begin
            if (exp_v.exists(ek(d, cyc))) begin
                check($sformatf("dut%0d cycle %0d outputs", d, cyc),
                      32'(dout[d]), 32'(exp_v[ek(d, cyc)]));
                exp_v.delete(ek(d, cyc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_v.num() != 0 && k < 3000) begin
            tick(1);
            k++;
        end
        check("pending expectations", 32'(exp_v.num()), 32'd0);
    endtask

    task automatic launch(input int d, input int n, output int c0, output int last);
        num_iter = 8'(n);
        start[d] = 1'b1;
        c0       = cyc;
        last     = build_run(d, c0, n);
        tick(1);
        start[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int c0, last, rs0, gs0, dn0;

        for (int c = 1; c <= 4; c++)
            for (int d = 0; d < ND; d++) put(d, c, '0);
        tick(3);
        reset = 1'b0;
        drain();

        // Two partitions, one iteration, single-cycle engines: fixed cycle landmarks.
        s_lat[1] = 1;
        g_lat[1] = 1;
        launch(1, 1, c0, last);
        for (int r = cyc - c0; r <= 10; r = cyc - c0) begin
            if (r == 1 || r == 4) check($sformatf("restart at %0d", r), dout[1].restart, 1);
            if (r == 2) check("partition at 2", dout[1].psel, 0);
            if (r == 5) check("partition at 5", dout[1].psel, 1);
            if (r == 7) check("gather_start at 7", dout[1].gstart, 1);
            if (r == 9) begin
                check("done at 9", dout[1].done, 1);
                check("iterations at 9", dout[1].iter, 1);
            end
            tick(1);
        end
        drain();

        // Zero iterations: immediate done, no engine activity.
        rs0 = rs_cnt[1];
        gs0 = gs_cnt[1];
        launch(1, 0, c0, last);
        check("zero-iter done", dout[1].done, 1);
        check("zero-iter count", dout[1].iter, 0);
        drain();
        check("zero-iter restarts", 32'(rs_cnt[1] - rs0), 0);
        check("zero-iter gathers", 32'(gs_cnt[1] - gs0), 0);

        // Four partitions, three iterations.
        s_lat[0] = 1;
        g_lat[0] = 1;
        rs0 = rs_cnt[0];
        gs0 = gs_cnt[0];
        launch(0, 3, c0, last);
        drain();
        check("3x4 restarts", 32'(rs_cnt[0] - rs0), 12);
        check("3x4 gathers", 32'(gs_cnt[0] - gs0), 3);
        check("3x4 final count", dout[0].iter, 3);

        // Scatter done in the very cycle the watchdog expires must win.
        s_lat[0] = 8;
        g_lat[0] = 2;
        launch(0, 1, c0, last);
        drain();
        check("done-vs-watchdog error", dout[0].error, 0);

        // Scatter never completes: error after 8 cycles, sticky, cleared by the next start.
        s_lat[0] = 0;
        launch(0, 2, c0, last);
        drain();
        check("timeout error", dout[0].error, 1);
        check("timeout busy", dout[0].busy, 0);
        tick(3);
        check("error sticky", dout[0].error, 1);
        s_lat[0] = 2;
        g_lat[0] = 1;
        launch(0, 1, c0, last);
        check("restart clears error", dout[0].error, 0);
        check("restart partition", dout[0].psel, 0);
        drain();

        // Single partition.
        s_lat[2] = 2;
        g_lat[2] = 2;
        launch(2, 2, c0, last);
        drain();
        check("one-partition count", dout[2].iter, 2);

        // Gather never completes, then a start from ERROR.
        s_lat[1] = 1;
        g_lat[1] = 0;
        launch(1, 1, c0, last);
        drain();
        check("gather timeout error", dout[1].error, 1);
        launch(1, 0, c0, last);
        drain();

        // Start while busy is ignored; abort in GATHER returns to IDLE with no done pulse.
        s_lat[0] = 1;
        g_lat[0] = 3;
        dn0 = dn_cnt[0];
        launch(0, 1, c0, last);
        while (cyc < c0 + 5) tick(1);
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        while (cyc < c0 + 14) tick(1);
        abort[0] = 1'b1;
        start[0] = 1'b1;
        for (int c = c0 + 15; c <= last; c++) exp_v.delete(ek(0, c));
        put(0, c0 + 15, mk(0, 0, 3, 0, 0, 0, 0, 0));
        put(0, c0 + 16, mk(0, 0, 3, 0, 0, 0, 0, 0));
        tick(1);
        abort[0] = 1'b0;
        start[0] = 1'b0;
        check("abort busy", dout[0].busy, 0);
        drain();
        check("abort done pulses", 32'(dn_cnt[0] - dn0), 0);

        // Reset in SCATTER: everything zero next cycle; later scatter_done pulses ignored.
        s_lat[0] = 0;
        g_lat[0] = 1;
        launch(0, 1, c0, last);
        while (cyc < c0 + 4) tick(1);
        check("pre-reset enable", dout[0].enable, 1);
        reset = 1'b1;
        for (int c = c0 + 5; c <= last; c++) exp_v.delete(ek(0, c));
        for (int c = c0 + 5; c <= c0 + 10; c++)
            for (int d = 0; d < ND; d++) put(d, c, '0);
        tick(1);
        reset = 1'b0;
        s_force[0] = 1'b1;
        tick(2);
        s_force[0] = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
